// File: rtl/demux1to4_buf_pkg.sv
// Shared constants and select encoding for the buffered 1-to-4 demultiplexer.
// The select encoding matches the one used by mux4to1.
package demux_pkg;

  localparam int CH_NUM     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] CNT_FULL = 2'd2;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_e;

  function automatic logic [CH_NUM-1:0] sel_onehot(input logic [1:0] sel);
    logic [CH_NUM-1:0] oh;
    oh = '0;
    case (sel)
      SEL_A:   oh = 4'b0001;
      SEL_B:   oh = 4'b0010;
      SEL_C:   oh = 4'b0100;
      SEL_D:   oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_buf_if.sv
// Producer-side stream plus four consumer-side channels of the demultiplexer.
interface demux1to4_buf_if
  import demux_pkg::*;
#(
  parameter int OPERAND_SIZE = 8
);
  logic [OPERAND_SIZE-1:0]        in_data;
  logic [1:0]                     in_sel;
  logic                           in_valid;
  logic                           in_ready;
  logic [CH_NUM*OPERAND_SIZE-1:0] out_data;
  logic [CH_NUM-1:0]              out_valid;
  logic [CH_NUM-1:0]              out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux1to4_buf_ch_fifo.sv
// One 2-entry channel FIFO; occupancy count distinguishes full from empty
// since the 1-bit pointers alias.
module demux_ch_fifo
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux1to4_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted word into one of four
// independent 2-entry FIFOs, so a stalled consumer blocks only its own channel.
module demux1to4_buf
  import demux_pkg::*;
#(
  parameter int OPERAND_SIZE = 8
) (
  input logic           clk,
  input logic           rst_n,
  demux1to4_buf_if.slave bus
);

  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] empty;
  logic [CH_NUM-1:0] push_vec;
  logic [CH_NUM-1:0] pop_vec;

  // in_ready follows in_sel even when in_valid is low.
  assign bus.in_ready  = rst_n && !full[bus.in_sel];
  assign push_vec      = (bus.in_valid && bus.in_ready) ? sel_onehot(bus.in_sel) : '0;
  assign pop_vec       = bus.out_ready & ~empty;
  assign bus.out_valid = ~empty;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    demux_ch_fifo #(.W(OPERAND_SIZE)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_vec[k]),
      .push_data (bus.in_data),
      .pop       (pop_vec[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .head      (bus.out_data[k*OPERAND_SIZE +: OPERAND_SIZE])
    );
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed, table-driven bench for demux1to4_buf with a hand-written
// mid-operation reset sequence.
module tb_demux1to4_buf;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  demux1to4_buf_if #(.OPERAND_SIZE(8)) bus ();

  demux1to4_buf #(.OPERAND_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic        vld;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] sl(input int k, input logic [7:0] d);
    return {24'h0, d} << (8 * k);
  endfunction

  function automatic void add(input logic [1:0] sel, input logic [7:0] data,
                              input logic vld, input logic [3:0] ordy,
                              input logic rdy, input logic [3:0] ov,
                              input logic [31:0] od);
    vec_t v;
    v.sel = sel; v.data = data; v.vld = vld; v.ordy = ordy;
    v.rdy = rdy; v.ov = ov; v.od = od;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] vmask(input logic [3:0] ov);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (ov[k]) m |= sl(k, 8'hFF);
    return m;
  endfunction

  // Drive inputs, check in_ready before the edge, check outputs after it.
  task automatic step(input vec_t v, input int idx);
    bus.in_sel    = v.sel;
    bus.in_data   = v.data;
    bus.in_valid  = v.vld;
    bus.out_ready = v.ordy;
    #1;
    check($sformatf("in_ready[%0d]", idx), {31'b0, bus.in_ready}, {31'b0, v.rdy});
    @(posedge clk);
    #1;
    check($sformatf("out_valid[%0d]", idx), {28'b0, bus.out_valid}, {28'b0, v.ov});
    if (v.ov != 4'b0000)
      check($sformatf("out_data[%0d]", idx), bus.out_data & vmask(v.ov), v.od & vmask(v.ov));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat [4];
    tests  = 0;
    failed = 0;
    pat[0] = 8'h00; pat[1] = 8'h01; pat[2] = 8'hFE; pat[3] = 8'hFF;

    // one push per channel, all consumers ready
    add(2'd0, 8'h11, 1, 4'b1111, 1, 4'b0001, sl(0, 8'h11));
    add(2'd1, 8'h22, 1, 4'b1111, 1, 4'b0010, sl(1, 8'h22));
    add(2'd2, 8'h33, 1, 4'b1111, 1, 4'b0100, sl(2, 8'h33));
    add(2'd3, 8'h44, 1, 4'b1111, 1, 4'b1000, sl(3, 8'h44));
    add(2'd0, 8'h00, 0, 4'b1111, 1, 4'b0000, 32'h0);
    // ch2 stalled: fill, refuse third, then drain in order
    add(2'd2, 8'hAA, 1, 4'b1011, 1, 4'b0100, sl(2, 8'hAA));
    add(2'd2, 8'hBB, 1, 4'b1011, 1, 4'b0100, sl(2, 8'hAA));
    add(2'd2, 8'hCC, 1, 4'b1011, 0, 4'b0100, sl(2, 8'hAA));
    add(2'd2, 8'hCC, 1, 4'b1111, 0, 4'b0100, sl(2, 8'hBB));
    add(2'd2, 8'hCC, 1, 4'b1111, 1, 4'b0100, sl(2, 8'hCC));
    add(2'd2, 8'h00, 0, 4'b1111, 1, 4'b0000, 32'h0);
    // ch1 full and stalled does not block ch3
    add(2'd1, 8'h66, 1, 4'b1101, 1, 4'b0010, sl(1, 8'h66));
    add(2'd1, 8'h77, 1, 4'b1101, 1, 4'b0010, sl(1, 8'h66));
    add(2'd1, 8'h55, 1, 4'b1101, 0, 4'b0010, sl(1, 8'h66));
    add(2'd3, 8'h55, 1, 4'b1101, 1, 4'b1010, sl(1, 8'h66) | sl(3, 8'h55));
    add(2'd1, 8'h55, 1, 4'b1101, 0, 4'b0010, sl(1, 8'h66));
    add(2'd3, 8'h55, 1, 4'b1101, 1, 4'b1010, sl(1, 8'h66) | sl(3, 8'h55));
    add(2'd0, 8'h00, 0, 4'b1111, 1, 4'b0010, sl(1, 8'h77));
    add(2'd0, 8'h00, 0, 4'b1111, 1, 4'b0000, 32'h0);
    // ch0 simultaneous push and pop at count 1
    add(2'd0, 8'h01, 1, 4'b0000, 1, 4'b0001, sl(0, 8'h01));
    add(2'd0, 8'h02, 1, 4'b0001, 1, 4'b0001, sl(0, 8'h02));
    add(2'd0, 8'h00, 0, 4'b0001, 1, 4'b0000, 32'h0);
    // back-to-back streaming with pointer wrap
    for (int i = 0; i < 8; i++)
      add(2'd0, pat[i%4], 1, 4'b0001, 1, 4'b0001, sl(0, pat[i%4]));
    add(2'd0, 8'h00, 0, 4'b0001, 1, 4'b0000, 32'h0);

    // reset state
    rst_n         = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", {28'b0, bus.out_valid}, 32'h0);
    check("rst out_data", bus.out_data, 32'h0);
    check("rst in_ready", {31'b0, bus.in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], i);

    // fill ch0 and ch3, then reset mid-cycle
    step('{2'd0, 8'hA1, 1'b1, 4'b0000, 1'b1, 4'b0001, sl(0, 8'hA1)}, 100);
    step('{2'd0, 8'hA2, 1'b1, 4'b0000, 1'b1, 4'b0001, sl(0, 8'hA1)}, 101);
    step('{2'd3, 8'hD1, 1'b1, 4'b0000, 1'b1, 4'b1001, sl(0, 8'hA1) | sl(3, 8'hD1)}, 102);
    step('{2'd3, 8'hD2, 1'b1, 4'b0000, 1'b1, 4'b1001, sl(0, 8'hA1) | sl(3, 8'hD1)}, 103);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", {28'b0, bus.out_valid}, 32'h0);
    check("mid rst out_data", bus.out_data, 32'h0);
    check("mid rst in_ready", {31'b0, bus.in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step('{2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0}, 104);
    step('{2'd3, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0}, 105);
    step('{2'd0, 8'h5A, 1'b1, 4'b0000, 1'b1, 4'b0001, sl(0, 8'h5A)}, 106);
    step('{2'd0, 8'h00, 1'b0, 4'b0001, 1'b1, 4'b0000, 32'h0}, 107);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
# demux1to4_buf

Buffered 1-to-4 demultiplexer: the routing counterpart of `mux4to1`. It accepts one OPERAND_SIZE-bit stream with a 2-bit destination select and steers each accepted word into one of four independent 2-entry output FIFOs. Each FIFO has its own valid/ready handshake. It sits between a single producer (ALU/write-back path) and up to four consumers (register-file write ports, I/O port latches). A stalled consumer blocks only words destined to it.

## Interface
- OPERAND_SIZE, 8, data width of input and of each output channel
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  OPERAND_SIZE  word to route
- in_sel  in  2  destination: 00→ch0 (A), 01→ch1 (B), 10→ch2 (C), 11→ch3 (D)
- in_valid  in  1  producer has a word on in_data/in_sel
- in_ready  out  1  selected channel can accept this cycle
- out_data  out  4*OPERAND_SIZE  head word of channel k at bits [k*OPERAND_SIZE +: OPERAND_SIZE]
- out_valid  out  4  bit k: channel k FIFO non-empty
- out_ready  in  4  bit k: consumer k takes the head word this cycle

## Operation
- Per channel: 2-entry FIFO with 2-bit occupancy count (0,1,2), 1-bit write pointer and 1-bit read pointer.
- in_ready = rst_n && (count[in_sel] != 2). It is combinational from in_sel and the channel state and does not depend on in_valid.
- Push: in_valid && in_ready at a rising edge writes in_data into channel in_sel. Only one channel is pushed per cycle.
- Pop: out_valid[k] && out_ready[k] at a rising edge advances channel k's read pointer. Any subset of the four channels may pop in the same cycle.
- Simultaneous push and pop on the same channel:
  - count 1: count stays 1 and both pointers advance.
  - count 0: push only, because out_valid is low.
  - count 2: no push, because in_ready is low. Full channels have no pass-through.
- out_valid[k] = (count[k] != 0). out_data slice k = storage at read pointer k.
- Ordering: words leave each channel in the order they arrived on that channel. There is no ordering relation between channels.
- out_ready[k] while out_valid[k]=0 is ignored.
- in_sel while in_valid=0 is don't-care for state, but it still steers in_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - all counts and pointers = 0
  - all storage = 0, so out_data = 0
  - out_valid = 4'b0000
  - in_ready = 0 while rst_n is low
- After reset release: first edge with in_valid=1 and in_ready=1 accepts the word.
- Latency: a word pushed at edge N appears with out_valid[k]=1 after edge N; it can be popped at edge N+1. Minimum 1 cycle, with no combinational in→out path.
- Throughput:
  - 1 word/cycle into any channel whose consumer holds out_ready=1.
  - A channel with out_ready=0 fills after 2 pushes. in_ready then drops whenever in_sel points to it.
- out_data slice k is stable while out_valid[k]=1 and no pop occurs. When empty, it is don't-care (except 0 after reset).
- Reset mid-operation: all buffered words are discarded immediately. out_valid falls asynchronously with rst_n. No partial state survives.
- Pointer wrap: 1-bit pointers toggle 1→0 naturally. Occupancy alone distinguishes full from empty.

## Structure
- Shared package `demux_pkg`:
  - constants: CH_NUM=4, FIFO_DEPTH=2
  - SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11, the same encoding `mux4to1` uses
- Sub-module `demux_ch_fifo`:
  - one 2-entry FIFO with push, push_data, pop, full, empty, head
  - instantiated CH_NUM times via generate
  - top level decodes in_sel into a one-hot push vector and forms in_ready from the selected full flag

## Test plan
- Reset, then push 0x11/0x22/0x33/0x44 with sel 00/01/10/11 and out_ready=4'b1111 → each appears on its own slice one cycle after its push, with out_valid a one-hot pulse per word and other slices' valid low.
- out_ready[2]=0, push 0xAA, 0xBB, 0xCC to sel=10 → in_ready=1 for the first two and 0 for the third, count=2. Raise out_ready[2] → pops 0xAA then 0xBB, then 0xCC is accepted.
- Channel 1 full and stalled, alternate sel=01 and sel=11 with data 0x55 → sel=01 cycles show in_ready=0; sel=11 words 0x55 are accepted and delivered on ch3 unaffected.
- Channel 0 holding one word (0x01), push 0x02 while out_ready[0]=1 → same edge pops 0x01 and stores 0x02. count stays 1, then 0x02 is delivered next.
- Fill ch0 and ch3 to 2 words each, assert rst_n=0 mid-cycle → out_valid=0000 and out_data=0 immediately. After release, no stale words are emitted.
- Back-to-back 8 pushes 0x00,0x01,0xFE,0xFF repeating on sel=00 with out_ready[0]=1 → in order, no bubbles, pointers wrap correctly.
